spi_slave: RTL and testbench

- 16-bit SPI slave (peripheral) running entirely in the `i_Clk` domain; it oversamples an external SPI bus.
- Receives MSB-first words on MOSI and returns one valid pulse per completed word.
- Shifts a buffered 16-bit response word out on MISO simultaneously.
- Sits opposite `spi_master` on the same board-level link. Peer of the word-wide master, same mode numbering and word size.

---
 rtl/spi_slave.sv | 156 +++++++++++++++
 tb/tb_spi_slave.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: 16-bit SPI peripheral oversampled in i_Clk; pins act 3 cycles after their edge, one-entry TX buffer gated by o_TX_Ready.
// Optional `SPI_SLAVE_MISO_TRISTATE_EN` floats MISO whenever chip select is inactive.
module spi_slave #(
  parameter int SPI_MODE = 0
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic [15:0] i_TX_Word,
  input  logic        i_TX_DV,
  output logic        o_TX_Ready,
  output logic        o_RX_DV,
  output logic [15:0] o_RX_Word,
  input  logic        i_SPI_Clk,
  input  logic        i_SPI_CS_n,
  input  logic        i_SPI_MOSI,
  output logic        o_SPI_MISO
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic        r_cs_s1, r_cs_s2, r_cs_d;
  logic        r_mosi_s1, r_mosi_s2;
  logic [1:0]  r_sync_ok;
  logic        r_armed;
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_rx_shadow;
  logic [15:0] r_rx_word;
  logic        r_rx_dv;
  logic [15:0] r_tx_buf;
  logic        r_tx_full;
  logic [15:0] r_tx_shift;
  logic        r_miso;

  logic        w_active, w_cs_fall;
  logic        w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic        w_sample, w_shift, w_word_end, w_consume, w_tx_load;
  logic [15:0] w_next_word;
  logic [15:0] w_rx_next;

  // After reset the synchronisers hold fake idle values; r_armed waits until a
  // genuinely idle CS has propagated so a frame already in progress is ignored.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sclk_s1 <= CPOL;
      r_sclk_s2 <= CPOL;
      r_sclk_d  <= CPOL;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_sync_ok <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_sclk_s1 <= i_SPI_Clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= i_SPI_CS_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_mosi_s1 <= i_SPI_MOSI;
      r_mosi_s2 <= r_mosi_s1;
      r_sync_ok <= {r_sync_ok[0], 1'b1};
      r_armed   <= r_armed | (r_sync_ok[1] & r_cs_s2);
    end
  end

  assign w_active    = r_armed & ~r_cs_s2;
  assign w_cs_fall   = r_armed & r_cs_d & ~r_cs_s2;
  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = w_active & (CPHA ? w_trail : w_lead);
  assign w_shift     = w_active & (CPHA ? w_lead : w_trail);
  assign w_word_end  = w_sample & (r_bit_cnt == 4'd0);
  assign w_consume   = w_cs_fall | w_word_end;
  assign w_tx_load   = i_TX_DV & ~r_tx_full;
  assign w_next_word = r_tx_full ? r_tx_buf : 16'h0000;

  always_comb begin
    w_rx_next            = r_rx_shadow;
    w_rx_next[r_bit_cnt] = r_mosi_s2;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_bit_cnt   <= 4'd15;
      r_rx_shadow <= 16'h0000;
      r_rx_word   <= 16'h0000;
      r_rx_dv     <= 1'b0;
    end else begin
      r_rx_dv <= 1'b0;
      if (!w_active) begin
        r_bit_cnt <= 4'd15;
      end else if (w_sample) begin
        r_rx_shadow <= w_rx_next;
        if (r_bit_cnt == 4'd0) begin
          r_rx_word <= w_rx_next;
          r_rx_dv   <= 1'b1;
          r_bit_cnt <= 4'd15;
        end else begin
          r_bit_cnt <= r_bit_cnt - 4'd1;
        end
      end
    end
  end

  // A load coinciding with a consume is only possible while empty, so the
  // consume takes zeros and the new word stays buffered.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_buf  <= 16'h0000;
      r_tx_full <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_buf  <= i_TX_Word;
      r_tx_full <= 1'b1;
    end else if (w_consume) begin
      r_tx_full <= 1'b0;
    end
  end

  // CPHA=0 must present bit 15 before the first sample edge, so only the
  // frame-start load drives MISO directly; word boundaries wait for a shift edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_shift <= 16'h0000;
      r_miso     <= 1'b0;
    end else if (!w_active) begin
      r_miso <= 1'b0;
    end else if (w_consume) begin
      if (CPHA || !w_cs_fall) begin
        r_tx_shift <= w_next_word;
      end else begin
        r_miso     <= w_next_word[15];
        r_tx_shift <= {w_next_word[14:0], 1'b0};
      end
    end else if (w_shift) begin
      r_miso     <= r_tx_shift[15];
      r_tx_shift <= {r_tx_shift[14:0], 1'b0};
    end
  end

  assign o_TX_Ready = ~r_tx_full;
  assign o_RX_DV    = r_rx_dv;
  assign o_RX_Word  = r_rx_word;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign o_SPI_MISO = r_cs_s2 ? 1'bz : r_miso;
`else
  assign o_SPI_MISO = ~r_cs_s2 & r_miso;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: one spi_slave per SPI mode, each driven by a bit-banged master
// with directed words; expectations are hand-computed constants.
module tb_spi_slave;

  localparam int H = 6;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic        i_Clk   = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic [3:0]  sclk    = 4'b1100;
  logic [3:0]  cs_n    = 4'b1111;
  logic [3:0]  mosi    = 4'b0000;
  logic [3:0]  tx_dv   = 4'b0000;
  logic [15:0] tx_word [4] = '{default: 16'h0000};
  wire  [3:0]  tx_ready, rx_dv, miso;
  wire  [15:0] rx_word [4];
  int          dv_cnt [4] = '{default: 0};
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 i_Clk = ~i_Clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g)) u_dut (
      .i_Clk      (i_Clk),
      .i_Rst_L    (i_Rst_L),
      .i_TX_Word  (tx_word[g]),
      .i_TX_DV    (tx_dv[g]),
      .o_TX_Ready (tx_ready[g]),
      .o_RX_DV    (rx_dv[g]),
      .o_RX_Word  (rx_word[g]),
      .i_SPI_Clk  (sclk[g]),
      .i_SPI_CS_n (cs_n[g]),
      .i_SPI_MOSI (mosi[g]),
      .o_SPI_MISO (miso[g])
    );
  end

  always @(posedge i_Clk)
    for (int k = 0; k < 4; k++)
      if (rx_dv[k] === 1'b1) dv_cnt[k] <= dv_cnt[k] + 1;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic tx_load(input int m, input logic [15:0] w);
    tx_word[m] = w;
    tx_dv[m]   = 1'b1;
    @(negedge i_Clk);
    tx_dv[m]   = 1'b0;
  endtask

  // Master: CPHA=0 samples MISO on the leading edge, CPHA=1 on the trailing edge.
  task automatic spi_bits(input int m, input logic [15:0] w, input int nbits, output logic [15:0] r);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    r = 16'h0000;
    for (int i = 15; i > 15 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = w[i];
        wait_cyc(H);
        sclk[m] = ~cpol;
        r[i]    = miso[m];
        wait_cyc(H);
        sclk[m] = cpol;
      end else begin
        wait_cyc(H);
        sclk[m] = ~cpol;
        mosi[m] = w[i];
        wait_cyc(H);
        sclk[m] = cpol;
        r[i]    = miso[m];
      end
    end
  endtask

  task automatic run_frame(input int m, input logic [15:0] w, output logic [15:0] r);
    cs_n[m] = 1'b0;
    wait_cyc(H);
    spi_bits(m, w, 16, r);
    wait_cyc(H);
    cs_n[m] = 1'b1;
    wait_cyc(2 * H);
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0;
    wait_cyc(3);
    i_Rst_L = 1'b1;
    wait_cyc(4);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (tx_ready[k] !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready[%0d]: got %b want 1", k, tx_ready[k]); end
      n_cmp++; if (rx_dv[k] !== 1'b0) begin n_err++; $display("FAIL reset_rx_dv[%0d]: got %b want 0", k, rx_dv[k]); end
      n_cmp++; if (rx_word[k] !== 16'h0000) begin n_err++; $display("FAIL reset_rx_word[%0d]: got %h want 0000", k, rx_word[k]); end
      n_cmp++; if (miso[k] !== MISO_IDLE) begin n_err++; $display("FAIL reset_miso[%0d]: got %b want %b", k, miso[k], MISO_IDLE); end
    end
  endtask

  task automatic test_mode0();
    logic [15:0] r;
    int d;
    tx_load(0, 16'hA55A);
    n_cmp++; if (tx_ready[0] !== 1'b0) begin n_err++; $display("FAIL mode0_ready_loaded: got %b want 0", tx_ready[0]); end
    cs_n[0] = 1'b0;
    wait_cyc(5);
    n_cmp++; if (tx_ready[0] !== 1'b1) begin n_err++; $display("FAIL mode0_ready_consumed: got %b want 1", tx_ready[0]); end
    wait_cyc(H - 5);
    d = dv_cnt[0];
    spi_bits(0, 16'h1234, 16, r);
    wait_cyc(H);
    cs_n[0] = 1'b1;
    wait_cyc(2 * H);
    n_cmp++; if (r !== 16'hA55A) begin n_err++; $display("FAIL mode0_miso: got %h want a55a", r); end
    n_cmp++; if (rx_word[0] !== 16'h1234) begin n_err++; $display("FAIL mode0_rx_word: got %h want 1234", rx_word[0]); end
    n_cmp++; if (dv_cnt[0] - d !== 1) begin n_err++; $display("FAIL mode0_rx_dv_pulses: got %0d want 1", dv_cnt[0] - d); end
  endtask

  task automatic test_modes();
    logic [15:0] r;
    int d;
    for (int m = 1; m < 4; m++) begin
      tx_load(m, 16'hBEEF);
      d = dv_cnt[m];
      run_frame(m, 16'hF00D, r);
      n_cmp++; if (r !== 16'hBEEF) begin n_err++; $display("FAIL mode%0d_miso: got %h want beef", m, r); end
      n_cmp++; if (rx_word[m] !== 16'hF00D) begin n_err++; $display("FAIL mode%0d_rx_word: got %h want f00d", m, rx_word[m]); end
      n_cmp++; if (dv_cnt[m] - d !== 1) begin n_err++; $display("FAIL mode%0d_rx_dv_pulses: got %0d want 1", m, dv_cnt[m] - d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r1, r2, r3;
    int d, m;
    for (int i = 0; i < 2; i++) begin
      m = (i == 0) ? 0 : 3;
      tx_load(m, 16'h1357);
      cs_n[m] = 1'b0;
      wait_cyc(H);
      tx_load(m, 16'h2468);
      d = dv_cnt[m];
      spi_bits(m, 16'h0001, 16, r1);
      wait_cyc(4);
      n_cmp++; if (rx_word[m] !== 16'h0001) begin n_err++; $display("FAIL b2b%0d_word1: got %h want 0001", m, rx_word[m]); end
      spi_bits(m, 16'h8000, 16, r2);
      wait_cyc(4);
      n_cmp++; if (rx_word[m] !== 16'h8000) begin n_err++; $display("FAIL b2b%0d_word2: got %h want 8000", m, rx_word[m]); end
      spi_bits(m, 16'hFFFF, 16, r3);
      wait_cyc(H);
      cs_n[m] = 1'b1;
      wait_cyc(2 * H);
      n_cmp++; if (r1 !== 16'h1357) begin n_err++; $display("FAIL b2b%0d_miso1: got %h want 1357", m, r1); end
      n_cmp++; if (r2 !== 16'h2468) begin n_err++; $display("FAIL b2b%0d_miso2: got %h want 2468", m, r2); end
      n_cmp++; if (r3 !== 16'h0000) begin n_err++; $display("FAIL b2b%0d_miso3: got %h want 0000", m, r3); end
      n_cmp++; if (rx_word[m] !== 16'hFFFF) begin n_err++; $display("FAIL b2b%0d_word3: got %h want ffff", m, rx_word[m]); end
      n_cmp++; if (dv_cnt[m] - d !== 3) begin n_err++; $display("FAIL b2b%0d_rx_dv_pulses: got %0d want 3", m, dv_cnt[m] - d); end
    end
  endtask

  task automatic test_partial();
    logic [15:0] r;
    int d;
    cs_n[0] = 1'b0;
    wait_cyc(H);
    d = dv_cnt[0];
    spi_bits(0, 16'h00FF, 9, r);
    wait_cyc(H);
    cs_n[0] = 1'b1;
    wait_cyc(2 * H);
    n_cmp++; if (dv_cnt[0] - d !== 0) begin n_err++; $display("FAIL partial_rx_dv: got %0d pulses want 0", dv_cnt[0] - d); end
    n_cmp++; if (rx_word[0] !== 16'hFFFF) begin n_err++; $display("FAIL partial_rx_hold: got %h want ffff", rx_word[0]); end
    d = dv_cnt[0];
    run_frame(0, 16'h5A5A, r);
    n_cmp++; if (rx_word[0] !== 16'h5A5A) begin n_err++; $display("FAIL partial_next_word: got %h want 5a5a", rx_word[0]); end
    n_cmp++; if (dv_cnt[0] - d !== 1) begin n_err++; $display("FAIL partial_next_dv: got %0d want 1", dv_cnt[0] - d); end
    n_cmp++; if (r !== 16'h0000) begin n_err++; $display("FAIL partial_empty_miso: got %h want 0000", r); end
  endtask

  task automatic test_tx_ignored();
    logic [15:0] r;
    tx_load(2, 16'h2222);
    n_cmp++; if (tx_ready[2] !== 1'b0) begin n_err++; $display("FAIL ign_ready_loaded: got %b want 0", tx_ready[2]); end
    tx_load(2, 16'h1111);
    n_cmp++; if (tx_ready[2] !== 1'b0) begin n_err++; $display("FAIL ign_ready_still_full: got %b want 0", tx_ready[2]); end
    run_frame(2, 16'h0F0F, r);
    n_cmp++; if (r !== 16'h2222) begin n_err++; $display("FAIL ign_miso: got %h want 2222", r); end
    n_cmp++; if (rx_word[2] !== 16'h0F0F) begin n_err++; $display("FAIL ign_rx_word: got %h want 0f0f", rx_word[2]); end
    n_cmp++; if (tx_ready[2] !== 1'b1) begin n_err++; $display("FAIL ign_ready_after: got %b want 1", tx_ready[2]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] r;
    int d;
    tx_load(0, 16'h3C3C);
    cs_n[0] = 1'b0;
    wait_cyc(H);
    spi_bits(0, 16'hC3C3, 7, r);
    i_Rst_L = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (tx_ready[k] !== 1'b1) begin n_err++; $display("FAIL rst_mid_tx_ready[%0d]: got %b want 1", k, tx_ready[k]); end
      n_cmp++; if (rx_dv[k] !== 1'b0) begin n_err++; $display("FAIL rst_mid_rx_dv[%0d]: got %b want 0", k, rx_dv[k]); end
      n_cmp++; if (rx_word[k] !== 16'h0000) begin n_err++; $display("FAIL rst_mid_rx_word[%0d]: got %h want 0000", k, rx_word[k]); end
      n_cmp++; if (miso[k] !== MISO_IDLE) begin n_err++; $display("FAIL rst_mid_miso[%0d]: got %b want %b", k, miso[k], MISO_IDLE); end
    end
    wait_cyc(2);
    i_Rst_L = 1'b1;
    d = dv_cnt[0];
    spi_bits(0, 16'hFFFF, 16, r);
    wait_cyc(H);
    cs_n[0] = 1'b1;
    wait_cyc(2 * H);
    n_cmp++; if (dv_cnt[0] - d !== 0) begin n_err++; $display("FAIL rst_stale_frame_dv: got %0d want 0", dv_cnt[0] - d); end
    n_cmp++; if (rx_word[0] !== 16'h0000) begin n_err++; $display("FAIL rst_stale_frame_word: got %h want 0000", rx_word[0]); end
    n_cmp++; if (miso[0] !== MISO_IDLE) begin n_err++; $display("FAIL rst_idle_miso: got %b want %b", miso[0], MISO_IDLE); end
    tx_load(0, 16'h3C3C);
    d = dv_cnt[0];
    run_frame(0, 16'hC3C3, r);
    n_cmp++; if (rx_word[0] !== 16'hC3C3) begin n_err++; $display("FAIL rst_next_word: got %h want c3c3", rx_word[0]); end
    n_cmp++; if (dv_cnt[0] - d !== 1) begin n_err++; $display("FAIL rst_next_dv: got %0d want 1", dv_cnt[0] - d); end
    n_cmp++; if (r !== 16'h3C3C) begin n_err++; $display("FAIL rst_next_miso: got %h want 3c3c", r); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_partial();
    test_tx_ignored();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
